// File: rtl/clause_streamer_pkg.sv
// common: shared CNF sizing for the solver front end and the clause record type.
package common;
   localparam int number_literal = 5;
   localparam int number_clause  = 10;
   localparam int addr_w = $clog2(number_clause);
   localparam int wcnt_w = $clog2(number_clause + 1);
   localparam int rcnt_w = $clog2(2 * number_clause);

   typedef struct packed {
      logic [number_literal-1:0] pos;
      logic [number_literal-1:0] neg;
   } clause_t;
endpackage

// File: rtl/clause_streamer_buffer.sv
// clause_buffer: per-slot clause register file, one write port, one combinational read port.
module clause_buffer
   import common::*;
(
   input  logic              clock,
   input  logic              clear,
   input  logic              we,
   input  logic [addr_w-1:0] waddr,
   input  clause_t           wdata,
   input  logic [addr_w-1:0] raddr,
   output clause_t           rdata
);
   clause_t mem_q [number_clause];

   always_ff @(posedge clock) begin
      if (clear) begin
         for (int k = 0; k < number_clause; k++) mem_q[k] <= '0;
      end else if (we) begin
         mem_q[waddr] <= wdata;
      end
   end

   assign rdata = mem_q[raddr];
endmodule

// File: rtl/clause_streamer.sv
// clause_streamer: buffers a CNF formula clause by clause, then replays it to the solver
// as two words per slot, padding unused slots with empty clauses.
module clause_streamer
   import common::*;
(
   input  logic                      clock,
   input  logic                      reset,
   input  logic                      clause_valid,
   output logic                      clause_ready,
   input  logic [number_literal-1:0] clause_pos,
   input  logic [number_literal-1:0] clause_neg,
   input  logic                      clause_last,
   output logic                      load,
   output logic [number_literal-1:0] i,
   output logic                      done
);
   localparam logic [1:0] COLLECT = 2'd0;
   localparam logic [1:0] STREAM  = 2'd1;
   localparam logic [1:0] DONE    = 2'd2;
   localparam logic [wcnt_w-1:0] full_cnt  = wcnt_w'(number_clause);
   localparam logic [wcnt_w-1:0] last_slot = wcnt_w'(number_clause - 1);
   localparam logic [rcnt_w-1:0] last_word = rcnt_w'(2 * number_clause - 1);

   logic [1:0]                state_q, state_d;
   logic [wcnt_w-1:0]         wr_cnt_q, wr_cnt_d;
   logic [rcnt_w-1:0]         rd_cnt_q, rd_cnt_d;
   logic                      load_q, load_d, done_q, done_d;
   logic [number_literal-1:0] i_q, i_d, word;
   logic [addr_w-1:0]         slot;
   logic                      accept;
   clause_t                   rdata;

   assign clause_ready = !reset && state_q == COLLECT && wr_cnt_q < full_cnt;
   assign accept = clause_valid && clause_ready;
   assign slot = rd_cnt_q[rcnt_w-1:1];

   clause_buffer u_buf (
      .clock (clock),
      .clear (reset || state_q == DONE),
      .we    (accept),
      .waddr (wr_cnt_q[addr_w-1:0]),
      .wdata ({clause_pos, clause_neg}),
      .raddr (slot),
      .rdata (rdata)
   );

   // slots beyond the stored count read as empty clauses
   assign word = {1'b0, slot} < wr_cnt_q ? (rd_cnt_q[0] ? rdata.neg : rdata.pos) : '0;

   always_comb begin
      state_d  = state_q == COLLECT ? (accept && (clause_last || wr_cnt_q == last_slot) ? STREAM : COLLECT)
               : state_q == STREAM  ? (rd_cnt_q == last_word ? DONE : STREAM)
               : COLLECT;
      wr_cnt_d = state_q == DONE ? '0 : wr_cnt_q + wcnt_w'(accept);
      rd_cnt_d = state_q == STREAM && rd_cnt_q != last_word ? rd_cnt_q + 1'b1 : '0;
      load_d   = state_q == STREAM;
      i_d      = state_q == STREAM ? word : '0;
      done_d   = state_q == DONE;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q  <= COLLECT;
         wr_cnt_q <= '0;
         rd_cnt_q <= '0;
         load_q   <= 1'b0;
         i_q      <= '0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         wr_cnt_q <= wr_cnt_d;
         rd_cnt_q <= rd_cnt_d;
         load_q   <= load_d;
         i_q      <= i_d;
         done_q   <= done_d;
      end
   end

   assign load = load_q;
   assign i    = i_q;
   assign done = done_q;
endmodule

// File: tb/tb_clause_streamer.sv
// tb_clause_streamer: directed and random formulas checked against a slot/word model of the stream.
module tb_clause_streamer;
   import common::*;

   logic       clock = 0, reset = 1;
   logic       clause_valid = 0, clause_last = 0;
   logic [4:0] clause_pos = 0, clause_neg = 0;
   logic       clause_ready, load, done;
   logic [4:0] i;
   int         vec = 0, err = 0;
   logic [4:0] fp[$], fn[$];

   clause_streamer dut (
      .clock(clock), .reset(reset), .clause_valid(clause_valid), .clause_ready(clause_ready),
      .clause_pos(clause_pos), .clause_neg(clause_neg), .clause_last(clause_last),
      .load(load), .i(i), .done(done)
   );

   always #5 clock = ~clock;

   initial begin
      #200000;
      $display("FAIL watchdog obs=timeout exp=finish");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vec++;
      assert (obs === exp) else begin
         err++;
         $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
      end
   endtask

   task automatic send(input logic [4:0] p, input logic [4:0] n, input logic l);
      int t = 0;
      clause_valid = 1; clause_pos = p; clause_neg = n; clause_last = l;
      #1;
      while (!clause_ready && t < 100) begin
         @(negedge clock); #1; t++;
      end
      chk("send_timeout", 32'(t < 100), 1);
      @(negedge clock);
      clause_valid = 0;
      fp.push_back(p); fn.push_back(n);
   endtask

   function automatic logic [4:0] exp_word(input int m);
      if (m / 2 >= fp.size()) return 5'd0;
      return (m % 2) ? fn[m/2] : fp[m/2];
   endfunction

   task automatic run_stream();
      for (int m = 0; m < 2 * number_clause; m++) begin
         @(negedge clock);
         chk($sformatf("load_w%0d", m), 32'(load), 1);
         chk($sformatf("word_w%0d", m), 32'(i), 32'(exp_word(m)));
         chk("done_mid", 32'(done), 0);
         chk("ready_mid", 32'(clause_ready), 0);
      end
      @(negedge clock);
      chk("load_end", 32'(load), 0);
      chk("done_pulse", 32'(done), 1);
      chk("i_end", 32'(i), 0);
      chk("ready_after_done", 32'(clause_ready), 1);
   endtask

   task automatic six_clause();
      send(5'b11100, 5'b00000, 0);
      send(5'b00000, 5'b11100, 0);
      send(5'b00001, 5'b00010, 0);
      send(5'b00010, 5'b10000, 0);
      send(5'b01100, 5'b00000, 0);
      send(5'b11011, 5'b00100, 0);
      send(5'b01010, 5'b00001, 1);
   endtask

   initial begin
      logic [4:0] hp, hn;
      int n;
      repeat (2) @(negedge clock);
      chk("rst_load", 32'(load), 0);
      chk("rst_i", 32'(i), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_ready", 32'(clause_ready), 0);
      reset = 0;
      #1 chk("ready_after_rst", 32'(clause_ready), 1);

      fp.delete(); fn.delete();
      six_clause();
      chk("latency_load", 32'(load), 0);
      run_stream();
      @(negedge clock) chk("done_once", 32'(done), 0);

      fp.delete(); fn.delete();
      for (int k = 0; k < number_clause; k++) send(5'($urandom), 5'($urandom), 0);
      chk("ready_full", 32'(clause_ready), 0);
      run_stream();

      fp.delete(); fn.delete();
      hp = 5'($urandom); hn = 5'($urandom);
      send(5'b10000, 5'b00000, 1);
      clause_valid = 1; clause_pos = hp; clause_neg = hn; clause_last = 1;
      run_stream();
      fp.delete(); fn.delete();
      fp.push_back(hp); fn.push_back(hn);
      @(negedge clock);
      clause_valid = 0;
      run_stream();

      fp.delete(); fn.delete();
      six_clause();
      for (int m = 0; m < 5; m++) begin
         @(negedge clock);
         chk("pre_rst_word", 32'(i), 32'(exp_word(m)));
      end
      reset = 1;
      @(negedge clock);
      chk("midrst_load", 32'(load), 0);
      chk("midrst_i", 32'(i), 0);
      chk("midrst_done", 32'(done), 0);
      reset = 0;
      for (int c = 0; c < 25; c++) begin
         @(negedge clock);
         chk("no_done_after_rst", 32'(done), 0);
         chk("no_load_after_rst", 32'(load), 0);
      end
      fp.delete(); fn.delete();
      send(5'($urandom), 5'($urandom), 1);
      run_stream();

      fp.delete(); fn.delete();
      for (int k = 0; k < 8; k++) send(5'($urandom) | 5'b1, 5'($urandom) | 5'b1, k == 7);
      run_stream();
      fp.delete(); fn.delete();
      for (int k = 0; k < 3; k++) send(5'($urandom), 5'($urandom), k == 2);
      run_stream();

      for (int r = 0; r < 3; r++) begin
         fp.delete(); fn.delete();
         n = $urandom_range(1, number_clause);
         for (int k = 0; k < n; k++) send(5'($urandom), 5'($urandom), k == n - 1);
         run_stream();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vec, err);
      $finish;
   end
endmodule

// File: doc/clause_streamer.md
# clause_streamer

Hardware front end that feeds a CNF formula into the SAT solver `top` over its `load`/`i` load port. Clauses arrive one per handshake beat as a positive/negative literal mask pair and are buffered until the formula is complete. The block then replays the formula as the contiguous two-words-per-clause stream the solver expects. Unused clause slots are padded with empty clauses so that `load` is always high for exactly `2*number_clause` cycles.

## Interface

Parameters, from package `common`; no module-level overrides:
- `number_literal`, 5: literal count and mask width; bit `number_literal-1` is literal a, bit 0 is the last literal.
- `number_clause`, 10: clause slots the solver loads per formula.

Ports:
- `clock`  in  1  single clock; all state changes on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `clause_valid`  in  1  a clause is offered on `clause_pos`/`clause_neg`.
- `clause_ready`  out  1  block accepts the offered clause this cycle.
- `clause_pos`  in  `number_literal`  mask of literals that appear positive.
- `clause_neg`  in  `number_literal`  mask of literals that appear negated.
- `clause_last`  in  1  the offered clause is the final clause of the formula.
- `load`  out  1  drives the solver's `load`.
- `i`  out  `number_literal`  drives the solver's `i`.
- `done`  out  1  one-cycle pulse after the last stream word is sent.

## Operation

- The block has three states: COLLECT (the reset state), STREAM and DONE.
- COLLECT
  - `clause_ready` = 1 while fewer than `number_clause` clauses are stored.
  - A clause is accepted on any edge where `clause_valid` and `clause_ready` are both 1. It is written to slot `wr_cnt`, and `wr_cnt` increments.
  - The block moves to STREAM when the accepted beat has `clause_last`=1, or when it fills slot `number_clause-1`. In the second case `clause_last` is ignored.
- STREAM
  - `clause_ready` = 0.
  - A word counter `rd_cnt` runs from 0 to `2*number_clause-1`.
  - Even count `2k`: `i` = pos mask of slot k. Odd count `2k+1`: `i` = neg mask of slot k.
  - Slots with k ≥ `wr_cnt` emit 0 for both words.
  - After the final word, go to DONE.
- DONE
  - Lasts one cycle with `load`=0 and `done`=1.
  - Clears `wr_cnt`, `rd_cnt` and all slots to 0, then returns to COLLECT.
- Masks pass through unmodified. Tautologies (pos & neg ≠ 0) and all-zero clauses are not checked or filtered.

## Timing

- Reset values: `load`=0, `i`=0, `done`=0, `clause_ready`=0 in the reset cycle. Also state=COLLECT, `wr_cnt`=0, `rd_cnt`=0, all slots 0.
- `clause_ready` is 1 from the first cycle after `reset` deasserts.
- `load`, `i` and `done` are registered outputs.
- Latency: the final clause is accepted at edge N. After edge N+1, `load`=1 and `i`=pos of slot 0. After edge N+1+m, `i` carries word m.
- `load` stays 1 for exactly `2*number_clause` consecutive cycles with no gaps. It then falls to 0 in the same cycle that `done` is 1.
- `clause_ready` is 0 from edge N+1 until DONE ends. The first new clause can be accepted in the cycle after DONE.
- `clause_valid` while `clause_ready`=0 has no effect. The source must hold the beat.
- Reset mid-STREAM: the next edge forces `load`=0 and `i`=0 and discards the buffered formula. No `done` pulse is issued.

## Structure

- Package `common` holds `number_literal` and `number_clause`. It also gets a new `clause_t` packed struct {pos, neg}, each field `number_literal` bits, and the derived counter widths `$clog2(number_clause+1)` and `$clog2(2*number_clause)`.
- The FSM enum is local to the block.
- Sub-module `clause_buffer`: `number_clause` × `clause_t` register file.
  - One write port (`we`, `waddr`, `wdata`) and one combinational read port (`raddr`).
  - Synchronous `clear` input used by DONE and reset.
  - Out-of-range read slots, `raddr` ≥ stored count, are zero-masked by the parent.

## Test plan

- Six-clause formula, each beat written as (pos,neg): abc=(11100,00000), a'b'c'=(00000,11100), d'e=(00001,00010), a'd=(00010,10000), bc=(01100,00000), abc'de=(11011,00100); then bde'=(01010,00001) with `clause_last`=1.
  - The extra clause means the formula is seven clauses.
  - Required stream: the 14 words above in order, then 6 zero words. `load` is high for exactly 20 cycles, then `done` pulses once.
- Ten clauses with `clause_last`=0 throughout.
  - `clause_ready` drops after the 10th accept and the stream starts automatically.
  - All 20 words are from the buffer with no padding.
- Single clause (10000,00000) with `clause_last`=1 → i = 10000, 00000, then 18 zero words.
- Hold `clause_valid`=1 throughout the stream of the single-clause case.
  - No clause is accepted during STREAM or DONE.
  - The held beat is accepted in the first COLLECT cycle and starts a new formula.
- Assert `reset` at stream word 5 of the six-clause case.
  - `load`=0 and `i`=0 after the next edge, and `done` never pulses.
  - After reset deasserts, a fresh single-clause formula streams correctly with no stale data.
- Two back-to-back formulas.
  - The second formula's padding slots read 0, not the first formula's clauses.
